// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
//   Iterative 32-bit multiply/divide unit for MULT, MULTU, DIV and DIVU.
//   Feeds the HI and LO registers: hi_data/lo_data are their WriteData and
//   hi_write/lo_write are their 2-bit RegWrite strobes.
//   Radix-2 sequential datapath: shift-add multiply and restoring divide,
//   one bit per clock, followed by a single sign-correction cycle.
//
// Ports
//   clk       in   1      rising-edge clock
//   reset     in   1      asynchronous, active-high; clears all state
//   start     in   1      request; sampled only when busy=0
//   op        in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   rs_data   in   WIDTH  multiplicand / dividend
//   rt_data   in   WIDTH  multiplier / divisor
//   flush     in   1      abort the in-flight operation
//   busy      out  1      high in CALC and FIX
//   done      out  1      one-cycle pulse, results valid on hi_data/lo_data
//   hi_data   out  WIDTH  product high word / remainder
//   lo_data   out  WIDTH  product low word / quotient
//   hi_write  out  2      2'b11 during the done cycle, else 2'b00
//   lo_write  out  2      2'b11 during the done cycle, else 2'b00
// ---------------------------------------------------------------------------
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_data,
  output logic [WIDTH-1:0] lo_data,
  output logic [1:0]       hi_write,
  output logic [1:0]       lo_write
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, next_state;

  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   operand_b;
  logic [2*WIDTH-1:0] acc;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic               div_zero;
  logic [WIDTH-1:0]   rs_orig;

  logic               accept;
  logic               op_signed;
  logic               rs_neg;
  logic               rt_neg;
  logic [WIDTH-1:0]   rs_abs;
  logic [WIDTH-1:0]   rt_abs;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] div_next;

  logic [2*WIDTH-1:0] fix_prod;
  logic [WIDTH-1:0]   fix_quot;
  logic [WIDTH-1:0]   fix_rem;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  // A new operation is taken only from IDLE/DONE, and a same-cycle flush
  // vetoes it. Signed ops iterate on magnitudes; the signs are kept aside.
  always_comb begin
    accept    = ((state == IDLE) || (state == DONE)) && start && !flush;
    op_signed = ~op[0];
    rs_neg    = op_signed & rs_data[WIDTH-1];
    rt_neg    = op_signed & rt_data[WIDTH-1];
    rs_abs    = rs_neg ? -rs_data : rs_data;
    rt_abs    = rt_neg ? -rt_data : rt_data;
  end

  // One iteration of each algorithm. The multiply keeps the partial product
  // in the upper half and the unconsumed multiplier bits in the lower half,
  // shifting right. The divide keeps the partial remainder in the upper
  // half and shifts dividend bits out of the top of the lower half while
  // quotient bits enter at the bottom.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand_b} : '0);
    mul_next  = {mul_sum, acc[WIDTH-1:1]};
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, operand_b};
    div_ge    = ~div_diff[WIDTH+1];
    div_rem   = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    div_next  = {div_rem, acc[WIDTH-2:0], div_ge};
  end

  // Sign correction. Division by zero bypasses the datapath result and
  // reports an all-ones quotient with the untouched dividend as remainder.
  always_comb begin
    fix_prod = neg_q ? -acc : acc;
    fix_quot = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    fix_rem  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    fix_hi   = fix_prod[2*WIDTH-1:WIDTH];
    fix_lo   = fix_prod[WIDTH-1:0];
    if (is_div) begin
      if (div_zero) begin
        fix_hi = rs_orig;
        fix_lo = '1;
      end else begin
        fix_hi = fix_rem;
        fix_lo = fix_quot;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: CALC runs WIDTH iterations, FIX takes one cycle,
  // DONE lasts one cycle unless a new request chains straight into CALC.
  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: next_state = accept ? CALC : IDLE;
      CALC: begin
        if (flush) begin
          next_state = IDLE;
        end else if (count == CW'(WIDTH - 1)) begin
          next_state = FIX;
        end
      end
      FIX:     next_state = flush ? IDLE : DONE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration and result registers. A flushed
  // FIX leaves hi_data/lo_data holding the previous result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count     <= '0;
      operand_b <= '0;
      acc       <= '0;
      is_div    <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      div_zero  <= 1'b0;
      rs_orig   <= '0;
      hi_data   <= '0;
      lo_data   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            count    <= '0;
            is_div   <= op[1];
            neg_q    <= rs_neg ^ rt_neg;
            neg_r    <= rs_neg;
            div_zero <= (rt_data == '0);
            rs_orig  <= rs_data;
            if (op[1]) begin
              operand_b <= rt_abs;
              acc       <= {{WIDTH{1'b0}}, rs_abs};
            end else begin
              operand_b <= rs_abs;
              acc       <= {{WIDTH{1'b0}}, rt_abs};
            end
          end
        end
        CALC: begin
          count <= count + CW'(1);
          acc   <= is_div ? div_next : mul_next;
        end
        FIX: begin
          if (!flush) begin
            hi_data <= fix_hi;
            lo_data <= fix_lo;
          end
        end
        default: ;
      endcase
    end
  end

  // Status and write strobes decode directly from the state, so an async
  // reset drops them immediately.
  always_comb begin
    busy     = (state == CALC) || (state == FIX);
    done     = (state == DONE);
    hi_write = {2{done}};
    lo_write = {2{done}};
  end

endmodule
